dmem_arbiter: RTL and testbench

- Shares the single 32-byte, byte-addressed data memory between two requesters: the CPU MEM stage and a debug/loader port (testbench preload, register-dump readback).
- Models a multi-cycle memory array behind an IDLE/BUSY/DONE state machine.
- Holds the pipeline via `cpu_stall_o` while a CPU access is pending.
- Sits between the CPU MEM stage and the data-memory array, beside the hazard/flush logic.

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU MEM stage / debug port) arbiter in front of a multi-cycle
// 32-byte data memory; round-robin on ties, IDLE/BUSY/DONE sequencing.
module dmem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_done_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic              OWN_CPU    = 1'b0;
    localparam logic              OWN_DBG    = 1'b1;
    localparam logic [3:0]        CNT_INIT   = 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_owner;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              r_cpu_done;
    logic              r_dbg_ack;
    logic              r_mem_en;
    logic              r_mem_we;

    logic              w_grant;
    logic              w_pick_dbg;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // Grant decision: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        w_grant    = 1'b0;
        w_pick_dbg = 1'b0;
        if ((r_state == ST_IDLE) && start_i && (cpu_req_i || dbg_req_i)) begin
            w_grant = 1'b1;
            if (cpu_req_i && dbg_req_i) begin
                w_pick_dbg = (r_last == OWN_CPU);
            end else begin
                w_pick_dbg = dbg_req_i;
            end
        end else begin
            w_grant    = 1'b0;
            w_pick_dbg = 1'b0;
        end
    end

    // Request fields of the requester being granted.
    always_comb begin
        w_sel_we    = cpu_we_i;
        w_sel_addr  = cpu_addr_i;
        w_sel_wdata = cpu_wdata_i;
        if (w_pick_dbg) begin
            w_sel_we    = dbg_we_i;
            w_sel_addr  = dbg_addr_i;
            w_sel_wdata = dbg_wdata_i;
        end else begin
            w_sel_we    = cpu_we_i;
            w_sel_addr  = cpu_addr_i;
            w_sel_wdata = cpu_wdata_i;
        end
    end

    // Arbiter FSM; strobes are registered so the array sees clean, glitch-free controls.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_owner     <= OWN_CPU;
            r_last      <= OWN_DBG;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
            r_cpu_done  <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dbg_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_pick_dbg;
                        r_last   <= w_pick_dbg;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr & ALIGN_MASK;
                        r_wdata  <= w_sel_wdata;
                        r_cnt    <= CNT_INIT;
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_sel_we && (CNT_INIT == 4'd0);
                        r_state  <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we && (r_owner == OWN_CPU)) begin
                            r_cpu_rdata <= mem_rdata_i;
                        end else if (!r_we) begin
                            r_dbg_rdata <= mem_rdata_i;
                        end
                        r_mem_en   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_cpu_done <= (r_owner == OWN_CPU);
                        r_dbg_ack  <= (r_owner == OWN_DBG);
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                        r_mem_we <= r_we && (r_cnt == 4'd1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata_o = r_cpu_rdata;
    assign cpu_done_o  = r_cpu_done;
    assign dbg_rdata_o = r_dbg_rdata;
    assign dbg_ack_o   = r_dbg_ack;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    // Stall drops only in the CPU's DONE cycle; gated by reset so all outputs are 0 in reset.
    assign cpu_stall_o = rst_i & cpu_req_i & ~r_cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-timeline model checks the LATENCY=2
// instance every cycle; a LATENCY=1 instance is checked against a literal table.
module tb_dmem_arbiter;
    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b1;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [4:0]  cpu_addr_i = 5'd0;
    logic [31:0] cpu_wdata_i = 32'd0;
    logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [4:0]  dbg_addr_i = 5'd0;
    logic [31:0] dbg_wdata_i = 32'd0;
    logic [31:0] cpu_rdata_o, dbg_rdata_o, mem_wdata_o, mem_rdata_i;
    logic        cpu_done_o, cpu_stall_o, dbg_ack_o, mem_en_o, mem_we_o;
    logic [4:0]  mem_addr_o;
    logic [31:0] arr [8];

    logic        c1_req = 1'b0;
    logic [4:0]  c1_addr = 5'd0;
    logic [31:0] c1_rdata, d1_rdata, m1_wdata, m1_rdata;
    logic        c1_done, c1_stall, d1_ack, m1_en, m1_we;
    logic [4:0]  m1_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .LATENCY(LAT)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o),
        .cpu_stall_o(cpu_stall_o), .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
        .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o),
        .dbg_ack_o(dbg_ack_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .LATENCY(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(1'b1),
        .cpu_req_i(c1_req), .cpu_we_i(1'b0), .cpu_addr_i(c1_addr),
        .cpu_wdata_i(32'd0), .cpu_rdata_o(c1_rdata), .cpu_done_o(c1_done),
        .cpu_stall_o(c1_stall), .dbg_req_i(1'b0), .dbg_we_i(1'b0),
        .dbg_addr_i(5'd0), .dbg_wdata_i(32'd0), .dbg_rdata_o(d1_rdata),
        .dbg_ack_o(d1_ack), .mem_en_o(m1_en), .mem_we_o(m1_we),
        .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata), .mem_rdata_i(m1_rdata)
    );

    // Array behind u_dut: combinational read, write on the clock edge.
    assign mem_rdata_i = arr[mem_addr_o[4:2]];
    always @(posedge clk_i) begin
        if (mem_en_o && mem_we_o) arr[mem_addr_o[4:2]] <= mem_wdata_o;
    end
    // Read-only pattern memory behind u_dut1.
    assign m1_rdata = 32'hA5A5_0000 | {27'd0, m1_addr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a grant decided in IDLE cycle g gives BUSY cycles g+1..g+LAT,
    // DONE at g+LAT+1, and the next decision no earlier than g+LAT+2.
    int          cyc = 0;
    int          g_cyc = -100;
    logic        m_owner = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_wdata = 32'd0, m_cpu_rd = 32'd0, m_dbg_rd = 32'd0;
    logic [31:0] exp_mem [8] = '{default: 32'd0};

    always @(negedge clk_i) begin
        int  d;
        bit  busy, done;
        if (!rst_i) begin
            chk("rst_mem_en", mem_en_o, 0);
            chk("rst_mem_we", mem_we_o, 0);
            chk("rst_cpu_done", cpu_done_o, 0);
            chk("rst_dbg_ack", dbg_ack_o, 0);
            chk("rst_stall", cpu_stall_o, 0);
            chk("rst_cpu_rdata", cpu_rdata_o, 0);
            chk("rst_dbg_rdata", dbg_rdata_o, 0);
            g_cyc = -100; m_last = 1'b1; m_cpu_rd = 32'd0; m_dbg_rd = 32'd0;
        end else begin
            d    = cyc - g_cyc;
            busy = (d >= 1) && (d <= LAT);
            done = (d == LAT + 1);
            chk("m_mem_en", mem_en_o, busy);
            chk("m_mem_we", mem_we_o, busy && (d == LAT) && m_we);
            if (busy) begin
                chk("m_mem_addr", mem_addr_o, m_addr);
                chk("m_mem_wdata", mem_wdata_o, m_wdata);
            end
            chk("m_cpu_done", cpu_done_o, done && (m_owner == 1'b0));
            chk("m_dbg_ack", dbg_ack_o, done && (m_owner == 1'b1));
            chk("m_cpu_rdata", cpu_rdata_o, m_cpu_rd);
            chk("m_dbg_rdata", dbg_rdata_o, m_dbg_rd);
            chk("m_stall", cpu_stall_o, cpu_req_i && !(done && (m_owner == 1'b0)));
            if (busy && (d == LAT)) begin
                if (m_we) exp_mem[m_addr[4:2]] = m_wdata;
                else if (m_owner == 1'b0) m_cpu_rd = exp_mem[m_addr[4:2]];
                else m_dbg_rd = exp_mem[m_addr[4:2]];
            end
            if (!busy && !done && start_i && (cpu_req_i || dbg_req_i)) begin
                m_owner = (cpu_req_i && dbg_req_i) ? ~m_last : dbg_req_i;
                m_last  = m_owner;
                m_we    = m_owner ? dbg_we_i : cpu_we_i;
                m_addr  = {(m_owner ? dbg_addr_i[4:2] : cpu_addr_i[4:2]), 2'b00};
                m_wdata = m_owner ? dbg_wdata_i : cpu_wdata_i;
                g_cyc   = cyc;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete access on the chosen port; reports latency from raising req to the pulse.
    task automatic access(input bit dbg, input logic we, input logic [4:0] a, input logic [31:0] dat,
                          output int lat, output int n_we, output logic [4:0] bus_a,
                          output logic [31:0] we_d, output logic [31:0] rd, output int n_stall);
        lat = -1; n_we = 0; bus_a = 5'd0; we_d = 32'd0; rd = 32'd0; n_stall = 0;
        if (dbg) begin
            dbg_we_i = we; dbg_addr_i = a; dbg_wdata_i = dat; dbg_req_i = 1'b1;
        end else begin
            cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = dat; cpu_req_i = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (mem_en_o) bus_a = mem_addr_o;
            if (mem_we_o) begin n_we++; we_d = mem_wdata_o; end
            if (cpu_stall_o) n_stall++;
            if (dbg ? dbg_ack_o : cpu_done_o) begin
                lat = k;
                rd  = dbg ? dbg_rdata_o : cpu_rdata_o;
                break;
            end
        end
        dbg_req_i = 1'b0;
        cpu_req_i = 1'b0;
        tick();
    endtask

    int          lat, n_we, n_st;
    logic [4:0]  ba;
    logic [31:0] wd, rd;
    int          cpu_k [4];
    int          dbg_k [4];
    int          nc, nd;
    bit          e1_done [1:5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit          e1_en   [1:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit          e1_st   [1:5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] e1_rd   [1:5] = '{32'h0, 32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0000, 32'hA5A5_0008};

    initial begin
        // Reset with a CPU request pending: everything must read 0.
        cpu_req_i = 1'b1;
        tick(); tick();
        chk("reset_stall", cpu_stall_o, 0);
        chk("reset_mem_en", mem_en_o, 0);
        rst_i = 1'b1; cpu_req_i = 1'b0;
        tick();

        access(1'b1, 1'b1, 5'h00, 32'd5, lat, n_we, ba, wd, rd, n_st);
        chk("dbgwr_lat", lat, 3);
        chk("dbgwr_nwe", n_we, 1);
        chk("dbgwr_addr", ba, 5'h00);
        chk("dbgwr_data", wd, 32'd5);
        access(1'b1, 1'b1, 5'h04, 32'hDEAD_BEEF, lat, n_we, ba, wd, rd, n_st);
        access(1'b0, 1'b1, 5'h09, 32'h1111_1111, lat, n_we, ba, wd, rd, n_st);
        chk("cpuwr_align", ba, 5'h08);
        chk("cpuwr_lat", lat, 3);

        access(1'b0, 1'b0, 5'h06, 32'd0, lat, n_we, ba, wd, rd, n_st);
        chk("cpurd_lat", lat, 3);
        chk("cpurd_addr", ba, 5'h04);
        chk("cpurd_data", rd, 32'hDEAD_BEEF);
        chk("cpurd_nstall", n_st, 2);
        chk("cpurd_nwe", n_we, 0);

        // CPU drops req mid-BUSY: write still commits and done still pulses.
        cpu_we_i = 1'b1; cpu_addr_i = 5'h0C; cpu_wdata_i = 32'h0C0C_0C0C; cpu_req_i = 1'b1;
        tick();
        cpu_req_i = 1'b0;
        tick(); tick();
        chk("drop_done", cpu_done_o, 1);
        tick();
        access(1'b1, 1'b0, 5'h0C, 32'd0, lat, n_we, ba, wd, rd, n_st);
        chk("drop_commit", rd, 32'h0C0C_0C0C);

        // Grants held off while start_i is low.
        start_i = 1'b0;
        cpu_we_i = 1'b0; cpu_addr_i = 5'h04; cpu_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("nostart_en", mem_en_o, 0);
            chk("nostart_stall", cpu_stall_o, 1);
        end
        start_i = 1'b1;
        tick();
        chk("start_grant", mem_en_o, 1);
        tick(); tick();
        chk("start_done", cpu_done_o, 1);
        chk("start_rdata", cpu_rdata_o, 32'hDEAD_BEEF);
        cpu_req_i = 1'b0;
        tick();

        // start_i falling mid-BUSY lets the access finish.
        dbg_we_i = 1'b0; dbg_addr_i = 5'h00; dbg_req_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        chk("stopbusy_ack", dbg_ack_o, 1);
        chk("stopbusy_rdata", dbg_rdata_o, 32'd5);
        dbg_req_i = 1'b0; start_i = 1'b1;
        tick();

        // Reset during a BUSY write: aborted with no strobe.
        cpu_we_i = 1'b1; cpu_addr_i = 5'h08; cpu_wdata_i = 32'hCAFE_F00D; cpu_req_i = 1'b1;
        tick();
        #1 rst_i = 1'b0;
        #1;
        chk("abort_en", mem_en_o, 0);
        chk("abort_we", mem_we_o, 0);
        chk("abort_stall", cpu_stall_o, 0);
        chk("abort_rdata", dbg_rdata_o, 0);
        cpu_we_i = 1'b0;
        dbg_we_i = 1'b0; dbg_addr_i = 5'h00; dbg_req_i = 1'b1;
        tick(); tick();
        chk("abort_array", arr[2], 32'h1111_1111);
        rst_i = 1'b1;

        // Both requests held: CPU wins the first tie after reset, then alternation.
        nc = 0; nd = 0;
        for (int k = 0; k < 4; k++) begin cpu_k[k] = -1; dbg_k[k] = -1; end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (cpu_done_o && nc < 4) begin cpu_k[nc] = k; nc++; end
            if (dbg_ack_o && nd < 4) begin dbg_k[nd] = k; nd++; end
            if (k == 3) chk("tie_cpu_rdata", cpu_rdata_o, 32'h1111_1111);
            if (k == 7) chk("tie_dbg_rdata", dbg_rdata_o, 32'd5);
        end
        chk("tie_cpu0", cpu_k[0], 3);
        chk("tie_dbg0", dbg_k[0], 7);
        chk("tie_cpu1", cpu_k[1], 11);
        chk("tie_dbg1", dbg_k[1], 15);
        cpu_req_i = 1'b0; dbg_req_i = 1'b0;
        tick(); tick(); tick(); tick();

        // LATENCY=1 instance: back-to-back reads of 0x00 then 0x08.
        c1_addr = 5'h00; c1_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("l1_done", c1_done, e1_done[k]);
            chk("l1_en", m1_en, e1_en[k]);
            chk("l1_stall", c1_stall, e1_st[k]);
            chk("l1_rdata", c1_rdata, e1_rd[k]);
            chk("l1_we", m1_we, 0);
            chk("l1_ack", d1_ack, 0);
            if (k == 4) chk("l1_addr", m1_addr, 5'h08);
            if (k == 2) c1_addr = 5'h08;
            if (k == 5) c1_req = 1'b0;
        end
        chk("l1_wdata", m1_wdata, 0);
        chk("l1_dbg_rdata", d1_rdata, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
